pc_gen: RTL
===========

# pc_gen

Parametrised program-counter generator for the pipelined MIPS fetch stage. It holds the fetch PC and picks the next PC each cycle from the exception vector, a resolved redirect, a hold, or sequential increment, in fixed priority. It also maintains a small return-address stack (RAS) that the decode stage pushes on calls and pops on returns. All outputs are registered and feed the IF stage and the ID-stage jump logic.

## Interface
Parameters:
- XLEN, 32, address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.
- EXC_VEC, 32'h8000_0180, PC value loaded on exception.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two, at least 2.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, reset, synchronous and active-high.
- pc_write, input, 1, 1 = advance sequentially; 0 = hold (hazard stall).
- exc_valid, input, 1, exception taken this cycle.
- redirect_valid, input, 1, branch or jump resolved taken.
- redirect_target, input, XLEN, target address for the redirect.
- ras_push, input, 1, call decoded; push ras_push_addr.
- ras_push_addr, input, XLEN, return address (call PC + 8 for MIPS delay slot; supplied by the caller).
- ras_pop, input, 1, return decoded; pop top entry.
- pc, output, XLEN, current fetch PC.
- pc_next_seq, output, XLEN, pc + INC (combinational from registered pc).
- pc_misaligned, output, 1, registered; 1 when the last loaded target had nonzero bits [1:0].
- ras_top, output, XLEN, current top-of-stack entry.
- ras_valid, output, 1, 1 when the stack holds at least one entry.

## Operation
- Next-PC selection, highest priority first:
  - rst → RESET_VEC.
  - exc_valid → EXC_VEC.
  - redirect_valid → {redirect_target[XLEN-1:2], 2'b00}.
  - !pc_write → pc unchanged.
  - otherwise pc + INC, wrapping modulo 2^XLEN.
- exc_valid and redirect_valid both override a stall (pc_write=0).
- pc_misaligned:
  - Set to |redirect_target[1:0] when a redirect is selected.
  - Cleared when an exception or sequential step is selected.
  - Held during a hold.
- RAS is a circular buffer with write pointer wp and count cnt (0..RAS_DEPTH).
  - Push only: write entry at wp, wp+1, cnt saturates at RAS_DEPTH. On overflow the oldest entry is overwritten silently.
  - Pop only: wp−1, cnt−1. A pop when cnt=0 is ignored, and wp does not move.
  - Push and pop together: the top entry is replaced by ras_push_addr. wp and cnt are unchanged. If cnt=0, this behaves as a push.
  - exc_valid clears cnt to 0; wp is unchanged and entries are stale.
- ras_top = entry[wp−1]. ras_valid = (cnt≠0). When ras_valid=0, ras_top is don't-care.
- RAS updates ignore pc_write. The decode stage gates push and pop itself.

## Timing
- Reset values: pc=RESET_VEC, pc_next_seq=RESET_VEC+INC, pc_misaligned=0, cnt=0, wp=0, ras_valid=0. Entry contents are not reset.
- Reset asserted mid-operation wins over every other input in the same cycle.
- Latency: an input sampled at edge N appears on pc, pc_misaligned and RAS outputs after edge N (one cycle).
- No internal pending state: a redirect asserted during a stall takes effect at the next edge. It is not deferred.
- Pointer arithmetic is modulo RAS_DEPTH, with log2(RAS_DEPTH)-bit pointers. cnt is log2(RAS_DEPTH)+1 bits wide.

## Structure
- Package pc_pkg holds:
  - enum pc_sel_e {SEL_RST, SEL_EXC, SEL_REDIR, SEL_HOLD, SEL_SEQ};
  - default RESET_VEC, EXC_VEC and INC constants.
- The selection is a priority encoder producing a pc_sel_e, followed by a registered mux.
- One sub-module: ras_stack (params XLEN, RAS_DEPTH; ports clk, rst, push, push_addr, pop, clear, top, valid). pc_gen drives clear from exc_valid.

## Test plan
- Reset then free-run: rst=1 for 2 cycles, then pc_write=1 → pc sequence 0x0, 0x4, 0x8, 0xC; pc_next_seq=pc+4.
- Stall vs redirect: pc=0x10, pc_write=0 for 2 cycles → pc stays 0x10. In the same stalled cycle, redirect_valid=1 with target 0x200 → pc=0x200 next cycle.
- Simultaneous events: exc_valid=1, redirect_valid=1, pc_write=0 → pc=0x8000_0180 and ras_valid=0. Asserting rst in the same cycle → pc=0x0.
- Misaligned redirect: target 0x103 → pc=0x100 and pc_misaligned=1. The next sequential step → pc=0x104 and pc_misaligned=0.
- RAS overflow and underflow (depth 4):
  - Push A, B, C, D, E → ras_top=E.
  - Four pops → tops D, C, B. After the fourth pop, ras_valid=0 because A was lost to overflow.
  - A fifth pop is ignored.
- RAS push+pop together: stack [A, B]; push X and pop in one cycle → ras_top=X, count still 2. A following pop → ras_top=A.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
package pc_pkg;

  localparam int unsigned PC_XLEN      = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h8000_0180;
  localparam int unsigned PC_INC       = 4;
  localparam int unsigned PC_RAS_DEPTH = 4;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_EXC,
    SEL_REDIR,
    SEL_HOLD,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push on calls, pop on returns, replace-top on
// simultaneous push+pop; oldest entry is silently overwritten on overflow.
module ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [XLEN-1:0] push_addr,
  input  logic            pop,
  input  logic            clear,
  output logic [XLEN-1:0] top,
  output logic            valid
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_wp;
  logic [CW-1:0]   r_cnt;

  logic [PW-1:0]   w_top_idx;
  logic            w_empty;
  logic            w_push_only;
  logic            w_replace;
  logic            w_pop_only;

  assign w_top_idx   = r_wp - PW'(1);
  assign w_empty     = (r_cnt == '0);
  // Push+pop on an empty stack degenerates to a plain push.
  assign w_push_only = !clear && push && (!pop || w_empty);
  assign w_replace   = !clear && push && pop && !w_empty;
  assign w_pop_only  = !clear && pop && !push && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (w_push_only) begin
      r_wp  <= r_wp + PW'(1);
      r_cnt <= (r_cnt == CW'(RAS_DEPTH)) ? r_cnt : r_cnt + CW'(1);
    end else if (w_pop_only) begin
      r_wp  <= r_wp - PW'(1);
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Entry storage carries no reset; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_push_only) begin
        r_mem[r_wp] <= push_addr;
      end else if (w_replace) begin
        r_mem[w_top_idx] <= push_addr;
      end
    end
  end

  assign top   = r_mem[w_top_idx];
  assign valid = !w_empty;

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority next-PC select (reset, exception,
// redirect, hold, sequential) plus the return-address stack.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PC_RESET_VEC),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(PC_EXC_VEC),
  parameter int unsigned     INC       = PC_INC,
  parameter int unsigned     RAS_DEPTH = PC_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            exc_valid,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_addr,
  input  logic            ras_pop,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next_seq,
  output logic            pc_misaligned,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_valid
);

  logic [XLEN-1:0] r_pc;
  logic            r_misaligned;
  pc_sel_e         w_sel;

  // Fixed-priority next-PC encoder; exception and redirect override a stall.
  always_comb begin
    w_sel = SEL_SEQ;
    if (rst)                 w_sel = SEL_RST;
    else if (exc_valid)      w_sel = SEL_EXC;
    else if (redirect_valid) w_sel = SEL_REDIR;
    else if (!pc_write)      w_sel = SEL_HOLD;
  end

  always_ff @(posedge clk) begin
    case (w_sel)
      SEL_RST: begin
        r_pc         <= RESET_VEC;
        r_misaligned <= 1'b0;
      end
      SEL_EXC: begin
        r_pc         <= EXC_VEC;
        r_misaligned <= 1'b0;
      end
      SEL_REDIR: begin
        r_pc         <= {redirect_target[XLEN-1:2], 2'b00};
        r_misaligned <= |redirect_target[1:0];
      end
      SEL_SEQ: begin
        r_pc         <= r_pc + XLEN'(INC);
        r_misaligned <= 1'b0;
      end
      default: begin
        r_pc         <= r_pc;
        r_misaligned <= r_misaligned;
      end
    endcase
  end

  assign pc            = r_pc;
  assign pc_next_seq   = r_pc + XLEN'(INC);
  assign pc_misaligned = r_misaligned;

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .push_addr (ras_push_addr),
    .pop       (ras_pop),
    .clear     (exc_valid),
    .top       (ras_top),
    .valid     (ras_valid)
  );

endmodule
